frame_dump_ctrl: RTL

Scheduler that sequences a snapshot dump of the downsample buffer over the debug UART on the 12 MHz system clock. Triggers from a debounced button or a strobe. Walks the buffer address space (x, y), fetches each 32-bit word with 1-cycle read latency, and serialises it as 4 bytes, MSB first. Paces bytes against uart_busy with a holdoff counter. Replaces ad-hoc dump logic in the board top level.

---
 rtl/frame_dump_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_dump_ctrl.sv
// Snapshot dump scheduler: walks the downsample buffer and streams each word as 4 bytes, MSB first, paced against uart_busy_i.
// Define FRAME_DUMP_HEADER_EN to prefix each dump with SYNC0, SYNC1 and the frame count.
module frame_dump_ctrl #(
  parameter int WIDTH_X       = 40,
  parameter int HEIGHT_Y      = 30,
  parameter int DEBOUNCE_BITS = 14,
  parameter int HOLDOFF_BITS  = 13
`ifdef FRAME_DUMP_HEADER_EN
  ,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
`endif
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        btn_i,
  input  logic        start_i,
  output logic [5:0]  read_x_o,
  output logic [4:0]  read_y_o,
  input  logic [31:0] read_data_i,
  input  logic        uart_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  frame_count_o
);

  // state  | meaning
  // IDLE   | waiting for trigger, address outputs hold
  // HDR    | sending SYNC0, SYNC1, frame count (header build only)
  // ADDR   | buffer address presented
  // FETCH  | read data valid, captured into shift register
  // SEND   | four bytes of the word, one per tx_ok
  // DONE   | one-cycle completion pulse, frame count bump
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef FRAME_DUMP_HEADER_EN
    S_HDR   = 3'd1,
`endif
    S_ADDR  = 3'd2,
    S_FETCH = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] DB_ONES = '1;
  localparam logic [DEBOUNCE_BITS-1:0] DB_PRE  = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};
  localparam logic [HOLDOFF_BITS-1:0]  HO_ONES = '1;
  localparam logic [5:0]               X_LAST  = 6'(WIDTH_X - 1);
  localparam logic [4:0]               Y_LAST  = 5'(HEIGHT_Y - 1);

  state_t                   state_q, state_d;
  logic                     btn_s1, btn_s2, btn_trig;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic [HOLDOFF_BITS-1:0]  ho_cnt;
  logic [5:0]               x_q, x_d;
  logic [4:0]               y_q, y_d;
  logic [1:0]               z_q, z_d;
  logic [31:0]              sh_q, sh_d;
  logic                     wr_q, wr_d;
  logic [7:0]               dat_q, dat_d;
  logic [7:0]               fc_q, fc_d;
  logic                     trig, tx_ok;
`ifdef FRAME_DUMP_HEADER_EN
  logic [1:0]               hdr_q, hdr_d;
`endif

  assign trig  = btn_trig | start_i;
  assign tx_ok = (ho_cnt == HO_ONES) && !uart_busy_i && !wr_q;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q  <= S_IDLE;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_trig <= 1'b0;
      db_cnt   <= '0;
      ho_cnt   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      sh_q     <= '0;
      wr_q     <= 1'b0;
      dat_q    <= '0;
      fc_q     <= '0;
`ifdef FRAME_DUMP_HEADER_EN
      hdr_q    <= '0;
`endif
    end else begin
      btn_s1 <= btn_i;
      btn_s2 <= btn_s1;
      if (!btn_s2)
        db_cnt <= '0;
      else if (db_cnt != DB_ONES)
        db_cnt <= db_cnt + 1'b1;
      // High only on the cycle the counter lands on all-ones: one trigger per press
      btn_trig <= btn_s2 && (db_cnt == DB_PRE);

      if (uart_busy_i)
        ho_cnt <= '0;
      else if (ho_cnt != HO_ONES)
        ho_cnt <= ho_cnt + 1'b1;

      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
      fc_q    <= fc_d;
`ifdef FRAME_DUMP_HEADER_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sh_d    = sh_q;
    wr_d    = 1'b0;
    dat_d   = dat_q;
    fc_d    = fc_q;
`ifdef FRAME_DUMP_HEADER_EN
    hdr_d   = hdr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          x_d = '0;
          y_d = '0;
`ifdef FRAME_DUMP_HEADER_EN
          hdr_d   = '0;
          state_d = S_HDR;
`else
          state_d = S_ADDR;
`endif
        end
      end
`ifdef FRAME_DUMP_HEADER_EN
      S_HDR: begin
        if (tx_ok) begin
          wr_d  = 1'b1;
          hdr_d = hdr_q + 2'd1;
          case (hdr_q)
            2'd0:    dat_d = SYNC0;
            2'd1:    dat_d = SYNC1;
            default: dat_d = fc_q;
          endcase
          if (hdr_q == 2'd2)
            state_d = S_ADDR;
        end
      end
`endif
      S_ADDR:  state_d = S_FETCH;
      S_FETCH: begin
        sh_d    = read_data_i;
        z_d     = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ok) begin
          wr_d  = 1'b1;
          dat_d = sh_q[31:24];
          sh_d  = {sh_q[23:0], 8'h00};
          z_d   = z_q + 2'd1;
          if (z_q == 2'd3) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              state_d = S_DONE;
            end else if (x_q == X_LAST) begin
              x_d     = '0;
              y_d     = y_q + 5'd1;
              state_d = S_ADDR;
            end else begin
              x_d     = x_q + 6'd1;
              state_d = S_ADDR;
            end
          end
        end
      end
      S_DONE: begin
        fc_d    = fc_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_x_o      = x_q;
  assign read_y_o      = y_q;
  assign uart_wr_o     = wr_q;
  assign uart_dat_o    = dat_q;
  assign frame_count_o = fc_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);

endmodule
